// File: rtl/strhw_msg_block_loader_pkg.sv
// strhw_msg_block_loader_pkg: shared types and constants for the Streebog message block loader
//   uint512        raw 512-bit block
//   blk_len_t      bit length carried by one block, 0..512
//   loader_state_t loader FSM states
package strhw_msg_block_loader_pkg;
  localparam int STRHW_BLOCK_BITS = 512;
  localparam int STRHW_BLOCK_BYTES = 64;
  typedef logic [STRHW_BLOCK_BITS-1:0] uint512;
  typedef logic [9:0] blk_len_t;
  typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} loader_state_t;
endpackage

// File: rtl/strhw_beat_insert.sv
// strhw_beat_insert: writes one LSB-aligned beat into a 512-bit accumulator at a byte offset
//   acc_i     current accumulator
//   beat_i    beat bytes, byte 0 is the first stream byte
//   off_i     byte offset of the beat inside the block
//   nbytes_i  valid bytes in the beat; the rest of the beat window is written 0
//   pad_i     also place the 0x01 pad byte right after the last valid byte
//   acc_o     updated accumulator
module strhw_beat_insert
  import strhw_msg_block_loader_pkg::*;
#(
  parameter int IN_BYTES = 8
) (
  input  uint512                    acc_i,
  input  logic [8*IN_BYTES-1:0]     beat_i,
  input  logic [6:0]                off_i,
  input  logic [3:0]                nbytes_i,
  input  logic                      pad_i,
  output uint512                    acc_o
);
  logic [8*IN_BYTES-1:0] keep;
  logic [6:0] pad_off;
  uint512 win;
  assign keep = ~({(8*IN_BYTES){1'b1}} << {nbytes_i, 3'b000});
  assign pad_off = off_i + {3'b000, nbytes_i};
  assign win = uint512'({(8*IN_BYTES){1'b1}}) << {off_i, 3'b000};
  // Pad byte can fall past the beat window; those bytes are already zero after a block clear.
  assign acc_o = (acc_i & ~win)
               | (uint512'(beat_i & keep) << {off_i, 3'b000})
               | (pad_i ? uint512'(1) << {pad_off, 3'b000} : '0);
endmodule

// File: rtl/strhw_msg_block_loader.sv
// strhw_msg_block_loader: packs a byte stream into padded 512-bit Streebog blocks with bit lengths
//   clk_i, rst_ni              clock, async active-low reset
//   data_i/valid_i/last_i/nbytes_i/ready_o   input beat stream
//   block_o/len_o/last_o/valid_o/ready_i     output block stream
//   STRHW_LOADER_BSWAP_EN      byte-reverse each beat (big-endian source, nbytes from the MSB end)
module strhw_msg_block_loader
  import strhw_msg_block_loader_pkg::*;
#(
  parameter int IN_BYTES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [8*IN_BYTES-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [3:0]            nbytes_i,
  output logic                  ready_o,
  output uint512                block_o,
  output blk_len_t              len_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i
);
  localparam int WPB = STRHW_BLOCK_BYTES / IN_BYTES;
  loader_state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  uint512 acc_q, acc_d, ins;
  blk_len_t len_q, len_d;
  logic last_q, last_d;
  logic [8*IN_BYTES-1:0] beat;
  logic [6:0] off, fill_n;
  logic fire, at_end, full, pad;
`ifdef STRHW_LOADER_BSWAP_EN
  for (genvar k = 0; k < IN_BYTES; k++) begin : g_bswap
    assign beat[8*k+:8] = data_i[8*(IN_BYTES-1-k)+:8];
  end
`else
  assign beat = data_i;
`endif
  assign off = 7'(cnt_q * IN_BYTES);
  assign fill_n = off + {3'b000, nbytes_i};
  assign fire = state_q == FILL && valid_i;
  assign at_end = cnt_q == 6'(WPB - 1);
  // A last beat that exactly fills the block leaves no room for the pad byte.
  assign full = at_end && nbytes_i == 4'(IN_BYTES);
  assign pad = fire && last_i && !full;
  strhw_beat_insert #(.IN_BYTES(IN_BYTES)) u_ins (
    .acc_i(acc_q), .beat_i(beat), .off_i(off), .nbytes_i(nbytes_i), .pad_i(pad), .acc_o(ins)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    len_d = len_q;
    last_d = last_q;
    if (fire) begin
      acc_d = ins;
      cnt_d = cnt_q + 6'd1;
      if (last_i) begin
        state_d = full ? EMIT_PAD : EMIT;
        len_d = full ? blk_len_t'(STRHW_BLOCK_BITS) : {fill_n, 3'b000};
        last_d = !full;
      end else if (at_end) begin
        state_d = EMIT;
        len_d = blk_len_t'(STRHW_BLOCK_BITS);
        last_d = 1'b0;
      end
    end else if (ready_i && state_q == EMIT) begin
      state_d = FILL;
      cnt_d = '0;
      acc_d = '0;
      len_d = '0;
      last_d = 1'b0;
    end else if (ready_i && state_q == EMIT_PAD) begin
      state_d = EMIT;
      acc_d = uint512'(1);
      len_d = '0;
      last_d = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      cnt_q <= '0;
      acc_q <= '0;
      len_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      len_q <= len_d;
      last_q <= last_d;
    end
  end
  assign ready_o = state_q == FILL;
  assign valid_o = state_q != FILL;
  assign block_o = acc_q;
  assign len_o = len_q;
  assign last_o = last_q;
  a_nbytes: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i && ready_o |-> nbytes_i <= 4'(IN_BYTES) && (last_i || nbytes_i == 4'(IN_BYTES)));
endmodule

// File: tb/tb_strhw_msg_block_loader.sv
// tb_strhw_msg_block_loader: random message stream against a padded-block reference model
module tb_strhw_msg_block_loader;
  localparam int IB = 8;
  typedef struct {
    logic [511:0] blk;
    logic [9:0]   len;
    logic         last;
  } exp_t;
  logic clk_i, rst_ni, valid_i, last_i, ready_o, last_o, valid_o, ready_i;
  logic [8*IB-1:0] data_i;
  logic [3:0] nbytes_i;
  logic [511:0] block_o;
  logic [9:0] len_o;
  exp_t exp_q[$];
  logic [7:0] msg[$];
  int checks = 0, errs = 0, stall_n = 0;
  strhw_msg_block_loader #(.IN_BYTES(IB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .nbytes_i(nbytes_i), .ready_o(ready_o), .block_o(block_o), .len_o(len_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );
  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  // Reference: m split into whole 64-byte blocks, then the remainder r bytes with 0x01 at byte r.
  task automatic push_model();
    int n = msg.size();
    int nf = n / 64;
    int r = n % 64;
    exp_t e;
    for (int b = 0; b < nf; b++) begin
      e.blk = '0;
      for (int i = 0; i < 64; i++) e.blk[8*i+:8] = msg[64*b+i];
      e.len = 10'd512;
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    e.blk = '0;
    for (int i = 0; i < r; i++) e.blk[8*i+:8] = msg[64*nf+i];
    e.blk[8*r+:8] = 8'h01;
    e.len = 10'(8 * r);
    e.last = 1'b1;
    exp_q.push_back(e);
  endtask
  function automatic logic [8*IB-1:0] mk_beat(input int p, input int nb);
    logic [8*IB-1:0] d;
    int idx;
    for (int k = 0; k < IB; k++) d[8*k+:8] = 8'($urandom);
    for (int k = 0; k < nb; k++) begin
`ifdef STRHW_LOADER_BSWAP_EN
      idx = IB - 1 - k;
`else
      idx = k;
`endif
      d[8*idx+:8] = msg[p+k];
    end
    return d;
  endfunction
  task automatic send_beat(input logic [8*IB-1:0] d, input int nb, input bit l);
    int t = 0;
    valid_i = 1;
    data_i = d;
    nbytes_i = 4'(nb);
    last_i = l;
    while (!ready_o && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      checks++;
      errs++;
      $display("FAIL beat_accept_timeout: ready_o=%0b after %0d cycles, want 1", ready_o, t);
    end
    @(negedge clk_i);
    valid_i = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk_i);
  endtask
  task automatic send_msg(input bit tail);
    int n = msg.size();
    int p = 0;
    int nb;
    push_model();
    if (n == 0) send_beat(mk_beat(0, 0), 0, 1);
    while (p < n) begin
      nb = (n - p < IB) ? n - p : IB;
      send_beat(mk_beat(p, nb), nb, (p + nb == n) && !(tail && nb == IB));
      p += nb;
    end
    if (n != 0 && tail && n % IB == 0) send_beat(mk_beat(0, 0), 0, 1);
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d blocks outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask
  // Monitor: owns ready_i, checks hold stability under backpressure and pops on each transfer.
  initial begin
    logic go, hold_v;
    logic [511:0] h_blk;
    logic [9:0] h_len;
    logic h_last;
    exp_t e;
    hold_v = 0;
    ready_i = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hold_v = 0;
        continue;
      end
      if (hold_v) begin
        chk("hold_valid_o", 512'(valid_o), 512'(1));
        chk("hold_ready_o", 512'(ready_o), 512'(0));
        chk("hold_block_o", block_o, h_blk);
        chk("hold_len_o", 512'(len_o), 512'(h_len));
        chk("hold_last_o", 512'(last_o), 512'(h_last));
      end
      go = stall_n == 0 && $urandom_range(0, 99) < 70;
      if (stall_n > 0 && valid_o) stall_n--;
      ready_i = go;
      hold_v = valid_o && !go;
      h_blk = block_o;
      h_len = len_o;
      h_last = last_o;
      if (valid_o && go) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_block: got len %0d last %0b, want no block", len_o, last_o);
        end else begin
          e = exp_q.pop_front();
          chk("block_o", block_o, e.blk);
          chk("len_o", 512'(len_o), 512'(e.len));
          chk("last_o", 512'(last_o), 512'(e.last));
        end
      end
    end
  end
  initial begin
    rst_ni = 0;
    valid_i = 0;
    last_i = 0;
    nbytes_i = 0;
    data_i = '0;
    repeat (3) @(negedge clk_i);
    #1 rst_ni = 1;
    @(negedge clk_i);
    chk("rst_ready_o", 512'(ready_o), 512'(1));
    chk("rst_valid_o", 512'(valid_o), 512'(0));
    chk("rst_block_o", block_o, 512'(0));
    chk("rst_len_o", 512'(len_o), 512'(0));
    chk("rst_last_o", 512'(last_o), 512'(0));
    msg.delete();
    send_msg(0);
    msg.delete();
    for (int i = 0; i < 63; i++) msg.push_back(8'(i));
    send_msg(0);
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    send_msg(0);
    drain();
    stall_n = 5;
    msg.delete();
    for (int i = 0; i < 72; i++) msg.push_back(8'($urandom));
    send_msg(0);
    drain();
    msg.delete();
    for (int i = 0; i < 24; i++) msg.push_back(8'($urandom));
    for (int b = 0; b < 3; b++) send_beat(mk_beat(8 * b, 8), 8, 0);
    #2 rst_ni = 0;
    #1;
    chk("async_rst_block_o", block_o, 512'(0));
    chk("async_rst_valid_o", 512'(valid_o), 512'(0));
    chk("async_rst_ready_o", 512'(ready_o), 512'(1));
    chk("async_rst_len_o", 512'(len_o), 512'(0));
    @(negedge clk_i);
    #1 rst_ni = 1;
    @(negedge clk_i);
    msg.delete();
    for (int i = 1; i <= 8; i++) msg.push_back(8'(i));
    send_msg(0);
    for (int m = 0; m < 40; m++) begin
      msg.delete();
      for (int i = 0, n = $urandom_range(0, 200); i < n; i++) msg.push_back(8'($urandom));
      send_msg(1'($urandom_range(0, 1)));
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
